// File: rtl/serial_parity_tx_pkg.sv
// Shared definitions for the serial parity transmitter: state encoding,
// frame constants and the serial parity step.
package serial_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam int   FRAME_OVH = 3;
  localparam logic IDLE_LVL  = 1'b1;

  // One step of the serial XOR parity accumulation.
  function automatic logic parity_step(input logic acc, input logic bit_in);
    return acc ^ bit_in;
  endfunction

endpackage

// File: rtl/serial_parity_tx_bit_timer.sv
// Bit-period timer: counts 0..BAUD_DIV-1 and flags the last cycle of each
// serial bit period.
module bit_timer #(
  parameter int BAUD_DIV = 1
) (
  input  logic CLK,
  input  logic RST,
  input  logic clr,
  output logic tick
);

  localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

  logic [CW-1:0] cnt;

  // Free-running wrap counter, held at zero while cleared.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt <= '0;
    end else if (clr || (cnt == LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/serial_parity_tx.sv
// Bit-serial framed transmitter: start bit, WIDTH data bits LSB first,
// serially accumulated parity bit, stop bit. SEL steers the downstream mux.
module serial_parity_tx
  import serial_tx_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int BAUD_DIV   = 1,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] DIN,
  input  logic             LOAD_VALID,
  output logic             LOAD_READY,
  output logic             SEL,
  output logic             BIT_OUT,
  output logic             BUSY,
  output logic             DONE
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] shift_next;
  logic             acc;
  logic [CNT_W-1:0] bit_cnt;
  logic             tick;
  logic             timer_clr;

  assign shift_next = shift_reg >> 1;
  // The timer is parked in IDLE so every frame starts on a fresh bit period.
  assign timer_clr  = (state == IDLE);

  bit_timer #(
    .BAUD_DIV(BAUD_DIV)
  ) u_bit_timer (
    .CLK (CLK),
    .RST (RST),
    .clr (timer_clr),
    .tick(tick)
  );

  // Frame sequencer with registered line outputs; each output is set one
  // edge ahead of the bit it represents.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      shift_reg  <= '0;
      acc        <= 1'b0;
      bit_cnt    <= '0;
      LOAD_READY <= 1'b0;
      SEL        <= 1'b0;
      BIT_OUT    <= IDLE_LVL;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (LOAD_VALID && LOAD_READY) begin
            shift_reg  <= DIN;
            acc        <= PARITY_ODD;
            bit_cnt    <= '0;
            state      <= START;
            LOAD_READY <= 1'b0;
            SEL        <= 1'b1;
            BUSY       <= 1'b1;
            BIT_OUT    <= 1'b0;
          end else begin
            LOAD_READY <= 1'b1;
            SEL        <= 1'b0;
            BUSY       <= 1'b0;
            BIT_OUT    <= IDLE_LVL;
          end
        end
        START: begin
          if (tick) begin
            state   <= DATA;
            BIT_OUT <= shift_reg[0];
          end
        end
        DATA: begin
          if (tick) begin
            acc       <= parity_step(acc, shift_reg[0]);
            shift_reg <= shift_next;
            bit_cnt   <= bit_cnt + CNT_W'(1);
            if (bit_cnt == LAST_BIT) begin
              state   <= PARITY;
              BIT_OUT <= parity_step(acc, shift_reg[0]);
            end else begin
              BIT_OUT <= shift_next[0];
            end
          end
        end
        PARITY: begin
          if (tick) begin
            state   <= STOP;
            BIT_OUT <= 1'b1;
          end
        end
        STOP: begin
          if (tick) begin
            state      <= IDLE;
            DONE       <= 1'b1;
            LOAD_READY <= 1'b1;
            SEL        <= 1'b0;
            BUSY       <= 1'b0;
            BIT_OUT    <= IDLE_LVL;
          end
        end
        default: begin
          state      <= IDLE;
          LOAD_READY <= 1'b0;
          SEL        <= 1'b0;
          BUSY       <= 1'b0;
          BIT_OUT    <= IDLE_LVL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_parity_tx.sv
// Bench for serial_parity_tx: two instances (even parity / BAUD_DIV=1 and
// odd parity / BAUD_DIV=4) checked against per-cycle expected line queues.
module tb_serial_parity_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din_a, din_b;
  logic       vld_a, vld_b;
  logic       rdy_a, sel_a, bit_a, busy_a, done_a;
  logic       rdy_b, sel_b, bit_b, busy_b, done_b;

  int checks = 0;
  int errors = 0;
  logic qa[$];
  logic qb[$];
  logic eb_a, eb_b;
  int exp_done_a = 0, exp_done_b = 0;
  int done_cnt_a = 0, done_cnt_b = 0;
  int run_a = 0, run_b = 0;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input bit ok);
    checks++;
    if (!ok) begin
      errors++;
      $error("FAIL %s", tag);
    end
  endtask

  serial_parity_tx #(.WIDTH(8), .BAUD_DIV(1), .PARITY_ODD(1'b0)) dut_a (
    .CLK(clk), .RST(rst), .DIN(din_a), .LOAD_VALID(vld_a), .LOAD_READY(rdy_a),
    .SEL(sel_a), .BIT_OUT(bit_a), .BUSY(busy_a), .DONE(done_a)
  );

  serial_parity_tx #(.WIDTH(8), .BAUD_DIV(4), .PARITY_ODD(1'b1)) dut_b (
    .CLK(clk), .RST(rst), .DIN(din_b), .LOAD_VALID(vld_b), .LOAD_READY(rdy_b),
    .SEL(sel_b), .BIT_OUT(bit_b), .BUSY(busy_b), .DONE(done_b)
  );

  function automatic logic [10:0] frame_bits(input logic [7:0] d, input logic odd);
    logic [10:0] f;
    f[0]   = 1'b0;
    f[8:1] = d;
    f[9]   = odd ^ (^d);
    f[10]  = 1'b1;
    return f;
  endfunction

  task automatic push_a(input logic [7:0] d);
    logic [10:0] f;
    f = frame_bits(d, 1'b0);
    for (int i = 0; i < 11; i++) qa.push_back(f[i]);
    exp_done_a++;
  endtask

  task automatic push_b(input logic [7:0] d);
    logic [10:0] f;
    f = frame_bits(d, 1'b1);
    for (int i = 0; i < 11; i++)
      for (int j = 0; j < 4; j++) qb.push_back(f[i]);
    exp_done_b++;
  endtask

  task automatic send_a(input logic [7:0] d);
    @(negedge clk);
    for (int i = 0; i < 300 && rdy_a !== 1'b1; i++) @(negedge clk);
    chk("rdy_a_wait", rdy_a === 1'b1);
    din_a = d;
    vld_a = 1'b1;
    push_a(d);
    @(posedge clk);
    #1 vld_a = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] d);
    @(negedge clk);
    for (int i = 0; i < 300 && rdy_b !== 1'b1; i++) @(negedge clk);
    chk("rdy_b_wait", rdy_b === 1'b1);
    din_b = d;
    vld_b = 1'b1;
    push_b(d);
    @(posedge clk);
    #1 vld_b = 1'b0;
  endtask

  // Line monitor for instance A: pops one expected bit per framed cycle.
  always @(negedge clk) begin
    if (rst) begin
      run_a = 0;
    end else if (sel_a) begin
      chk("a_busy", busy_a === 1'b1);
      chk("a_frame_expected", qa.size() != 0);
      if (qa.size() != 0) begin
        eb_a = qa.pop_front();
        chk("a_bit", bit_a === eb_a);
      end
      run_a++;
    end else begin
      chk("a_idle_line", bit_a === 1'b1);
      chk("a_idle_busy", busy_a === 1'b0);
      chk("a_done", done_a === (run_a != 0));
      if (done_a) begin
        done_cnt_a++;
        chk("a_frame_len", run_a == 11);
        chk("a_rdy_in_done", rdy_a === 1'b1);
      end
      run_a = 0;
    end
  end

  // Line monitor for instance B.
  always @(negedge clk) begin
    if (rst) begin
      run_b = 0;
    end else if (sel_b) begin
      chk("b_busy", busy_b === 1'b1);
      chk("b_frame_expected", qb.size() != 0);
      if (qb.size() != 0) begin
        eb_b = qb.pop_front();
        chk("b_bit", bit_b === eb_b);
      end
      run_b++;
    end else begin
      chk("b_idle_line", bit_b === 1'b1);
      chk("b_idle_busy", busy_b === 1'b0);
      chk("b_done", done_b === (run_b != 0));
      if (done_b) begin
        done_cnt_b++;
        chk("b_frame_len", run_b == 44);
        chk("b_rdy_in_done", rdy_b === 1'b1);
      end
      run_b = 0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    rst   = 1'b1;
    vld_a = 1'b0;
    vld_b = 1'b0;
    din_a = 8'h00;
    din_b = 8'h00;
    #1;
    chk("rst_sel", sel_a === 1'b0);
    chk("rst_bit", bit_a === 1'b1);
    chk("rst_busy", busy_a === 1'b0);
    chk("rst_done", done_a === 1'b0);
    chk("rst_rdy", rdy_a === 1'b0);
    chk("rst_rdy_b", rdy_b === 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rdy_after_rst", rdy_a === 1'b1);

    send_a(8'hA5);
    send_a(8'h07);
    send_b(8'h07);
    send_b(8'h01);

    @(negedge clk);
    for (int i = 0; i < 300 && rdy_a !== 1'b1; i++) @(negedge clk);
    din_a = 8'h3C;
    vld_a = 1'b1;
    push_a(8'h3C);
    @(posedge clk);
    #1 din_a = 8'hC3;
    push_a(8'hC3);
    @(negedge clk);
    for (int i = 0; i < 100 && done_a !== 1'b1; i++) @(negedge clk);
    chk("b2b_done_cycle", done_a === 1'b1);
    chk("b2b_rdy_in_done", rdy_a === 1'b1);
    @(posedge clk);
    #1 vld_a = 1'b0;
    @(negedge clk);
    chk("b2b_start_next", sel_a === 1'b1);
    chk("b2b_start_bit", bit_a === 1'b0);

    send_a(8'h96);
    repeat (3) @(posedge clk);
    #1;
    chk("busy_mid_frame", busy_a === 1'b1);
    din_a = 8'h55;
    vld_a = 1'b1;
    @(posedge clk);
    #1 vld_a = 1'b0;

    for (int i = 0; i < 500 && (qa.size() != 0 || qb.size() != 0 || rdy_a !== 1'b1 || rdy_b !== 1'b1); i++)
      @(negedge clk);
    chk("drained_a", qa.size() == 0);
    chk("drained_b", qb.size() == 0);

    send_a(8'hFF);
    repeat (5) @(posedge clk);
    #2;
    chk("pre_rst_sel", sel_a === 1'b1);
    rst = 1'b1;
    #1;
    chk("midrst_sel", sel_a === 1'b0);
    chk("midrst_bit", bit_a === 1'b1);
    chk("midrst_busy", busy_a === 1'b0);
    chk("midrst_done", done_a === 1'b0);
    chk("midrst_rdy", rdy_a === 1'b0);
    qa.delete();
    exp_done_a--;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rdy_before_edge", rdy_a === 1'b0);
    @(posedge clk);
    #1;
    chk("rdy_after_midrst", rdy_a === 1'b1);

    repeat (20) @(negedge clk);
    chk("done_count_a", done_cnt_a == exp_done_a);
    chk("done_count_b", done_cnt_b == exp_done_b);
    chk("final_queue_a", qa.size() == 0);
    chk("final_queue_b", qb.size() == 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
